int8_mac_result_buffer: RTL

- Downstream stage of the multi-lane MAC wrapper. Captures each single-cycle result pulse (result, we, rd_addr, hartid, id, overflow) into a small FIFO.
- Presents queued results to the CVXIF result interface with a valid/ready handshake, so core backpressure never loses a MAC result.
- Provides in_ready_o for the issue logic to hold off lane_exec, a saturating drop counter, and a sticky overflow flag.

---
 rtl/int8_mac_instr_pkg.sv | 8 +
 rtl/int8_mac_result_fifo.sv | 64 ++++++
 rtl/int8_mac_result_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/int8_mac_instr_pkg.sv
// Shared constants for the int8 MAC instruction path.
// Default sizing of the result buffer between the MAC wrapper and the CVXIF result port.
package int8_mac_instr_pkg;

    localparam int unsigned RESULT_BUF_DEPTH      = 4;
    localparam int unsigned RESULT_BUF_DROP_CNT_W = 8;

endpackage

// File: rtl/int8_mac_result_fifo.sv
// Generic synchronous FIFO: circular buffer with a separate occupancy count.
// Head data reads as zero when empty; flush clears pointers and count.
module int8_mac_result_fifo
    import int8_mac_instr_pkg::*;
#(
    parameter int unsigned DEPTH = RESULT_BUF_DEPTH,
    parameter type entry_t = logic [7:0],
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           data_i,
    input  logic             pop_i,
    output entry_t           data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count;
    assign data_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/int8_mac_result_buffer.sv
// Queues single-cycle MAC result pulses and presents them on the CVXIF result
// handshake; counts results lost to a full queue and remembers overflows.
module int8_mac_result_buffer
    import int8_mac_instr_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = RESULT_BUF_DEPTH,
    parameter type         hartid_t   = logic,
    parameter type         id_t       = logic,
    parameter int unsigned DROP_CNT_W = RESULT_BUF_DROP_CNT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [XLEN-1:0]            in_result_i,
    input  logic                       in_we_i,
    input  logic [4:0]                 in_rd_addr_i,
    input  hartid_t                    in_hartid_i,
    input  id_t                        in_id_i,
    input  logic                       in_overflow_i,
    output logic                       in_ready_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [XLEN-1:0]            result_data_o,
    output logic                       result_we_o,
    output logic [4:0]                 result_rd_o,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic                       result_ovf_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_sticky_o,
    input  logic                       ovf_clr_i,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            we;
        logic [4:0]      rd;
        hartid_t         hartid;
        id_t             id;
        logic            ovf;
    } entry_t;

    entry_t              wr_entry;
    entry_t              head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic                ovf_sticky;

    assign wr_entry = '{
        result: in_result_i,
        we:     in_we_i,
        rd:     in_rd_addr_i,
        hartid: in_hartid_i,
        id:     in_id_i,
        ovf:    in_overflow_i
    };

    // No pass-through when full: in_ready_o depends only on registered occupancy.
    assign in_ready_o     = !full;
    assign push           = in_valid_i && in_ready_o;
    assign result_valid_o = !empty;
    assign pop            = result_valid_o && result_ready_i;

    int8_mac_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    assign result_data_o   = head.result;
    assign result_we_o     = head.we;
    assign result_rd_o     = head.rd;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign result_ovf_o    = head.ovf;

    // A flush swallows same-cycle input silently; it is not a drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (in_valid_i && !in_ready_o && !flush_i && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (push && !flush_i && in_overflow_i) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign drop_cnt_o   = drop_cnt;
    assign ovf_sticky_o = ovf_sticky;

endmodule
